// File: rtl/decode_scoreboard.sv
// Decode-stage hazard and forwarding controller.
// Tracks every in-flight register write from EX (stage 1) to WB (stage DEPTH)
// and decides, for each decode source operand, whether to read the register
// file, forward from a later stage, or stall until the producer's result is
// ready. A MUL initiation-interval counter adds the structural hazard.
//
// Handshake: decode presents an instruction with id_valid. It leaves decode
// (issue=1) in the same cycle when it is neither flushed nor stalled. A
// stalled instruction must be held unchanged by decode until issue rises or
// it is flushed. There is no back-pressure beyond stall.
module decode_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 3,
  parameter int MUL_II   = 2,
  parameter int SEL_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic              rs_re,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rt_re,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              dst_we,
  input  logic [1:0]        op_class,
  output logic              stall,
  output logic              issue,
  output logic [SEL_W-1:0]  rs_fwd_sel,
  output logic [SEL_W-1:0]  rt_fwd_sel,
  output logic [SEL_W-1:0]  inflight
);

  localparam int MC_W = (MUL_II > 1) ? $clog2(MUL_II) : 1;

  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;

  // Per-stage tracker: entry k describes the instruction now in stage k.
  logic [DEPTH:1]    ent_valid;
  logic [ADDR_W-1:0] ent_addr [1:DEPTH];
  logic [SEL_W-1:0]  ent_lat  [1:DEPTH];

  logic [MC_W-1:0]   mul_cnt;

  logic              new_valid;
  logic [SEL_W-1:0]  new_lat;
  logic              rs_haz;
  logic              rt_haz;
  logic              rs_hit;
  logic              rt_hit;
  logic [SEL_W-1:0]  rs_sel_c;
  logic [SEL_W-1:0]  rt_sel_c;
  logic              struct_haz;
  logic              attempt;
  int                nxt_cnt;
  logic [SEL_W-1:0]  inflight_nxt;

  // Describe the entry the decode instruction would create if it issues.
  always_comb begin
    new_valid = dst_we && (dst_addr != '0);
    case (op_class)
      OP_LOAD: new_lat = SEL_W'(LOAD_LAT);
      OP_MUL:  new_lat = SEL_W'(MUL_LAT);
      default: new_lat = SEL_W'(1);
    endcase
  end

  // Youngest-match search per source: the first hit scanning from stage 1
  // shadows any older write to the same register.
  always_comb begin
    rs_sel_c = '0;
    rt_sel_c = '0;
    rs_haz   = 1'b0;
    rt_haz   = 1'b0;
    rs_hit   = 1'b0;
    rt_hit   = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!rs_hit && rs_re && (rs_addr != '0) && ent_valid[k] && (ent_addr[k] == rs_addr)) begin
        rs_hit = 1'b1;
        if (SEL_W'(k) >= ent_lat[k]) rs_sel_c = SEL_W'(k);
        else                         rs_haz   = 1'b1;
      end
      if (!rt_hit && rt_re && (rt_addr != '0) && ent_valid[k] && (ent_addr[k] == rt_addr)) begin
        rt_hit = 1'b1;
        if (SEL_W'(k) >= ent_lat[k]) rt_sel_c = SEL_W'(k);
        else                         rt_haz   = 1'b1;
      end
    end
  end

  // Stall / issue decision; flush overrides any hazard, reset blocks issue.
  always_comb begin
    struct_haz = (op_class == OP_MUL) && (mul_cnt != '0);
    attempt    = id_valid && !flush;
    stall      = attempt && (rs_haz || rt_haz || struct_haz);
    issue      = attempt && !stall && !rst;
    rs_fwd_sel = rs_sel_c;
    rt_fwd_sel = rt_sel_c;
  end

  // Number of valid entries once the pipeline has advanced this cycle.
  always_comb begin
    nxt_cnt = 0;
    if (issue && new_valid) nxt_cnt = nxt_cnt + 1;
    for (int k = 1; k < DEPTH; k++) begin
      if (ent_valid[k]) nxt_cnt = nxt_cnt + 1;
    end
    if (nxt_cnt > DEPTH) nxt_cnt = DEPTH;
    inflight_nxt = SEL_W'(nxt_cnt);
  end

  // Valid bits advance every cycle; stage 1 gets the new writer or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) ent_valid[k] <= ent_valid[k-1];
      ent_valid[1] <= issue && new_valid;
    end
  end

  // Entry payload shifts alongside the valid bits; it is ignored when invalid.
  always_ff @(posedge clk) begin
    for (int k = DEPTH; k >= 2; k--) begin
      ent_addr[k] <= ent_addr[k-1];
      ent_lat[k]  <= ent_lat[k-1];
    end
    ent_addr[1] <= dst_addr;
    ent_lat[1]  <= new_lat;
  end

  // MUL initiation-interval counter and registered in-flight count.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt  <= '0;
      inflight <= '0;
    end else begin
      if (issue && (op_class == OP_MUL)) mul_cnt <= MC_W'(MUL_II - 1);
      else if (mul_cnt != '0)            mul_cnt <= mul_cnt - 1'b1;
      inflight <= inflight_nxt;
    end
  end

endmodule
